// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the core memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DATA  = 3'd2,
    ST_STEP  = 3'd3,
    ST_ERROR = 3'd4
  } arb_state_t;

  localparam int unsigned ARB_TIMEOUT = 255;
  localparam int unsigned WAIT_W      = 8;

  function automatic logic is_access(input arb_state_t s);
    return (s == ST_FETCH) || (s == ST_DATA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_watchdog.sv
// ============================================================================
// Module      : bus_watchdog
// Description : Saturating bus wait counter; flags the cycle it reaches timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_watchdog
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ARB_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] CNT_MAX   = {WAIT_W{1'b1}};

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted in the non-ack cycle that takes the count to the timeout value.
  assign expired = inc && (count_q == LAST_WAIT);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Sequences instruction fetch and data access on one memory bus,
//               then pulses the core clock enable for a single step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [29:0] inst_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  output logic        core_clk_en,
  output logic [31:0] inst_q,
  output logic [31:0] rdata_q,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       armed_q;
  logic       err_q;
  logic       wd_clr;
  logic       wd_inc;
  logic       wd_expired;

  assign wd_inc = is_access(state_q) && !bus_ack;
  assign wd_clr = is_access(state_d) && (state_d != state_q);

  bus_watchdog u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      // armed_q holds off the first fetch until the second edge after reset.
      ST_IDLE: begin
        if (run && armed_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus_ack)         state_d = data_req ? ST_DATA : ST_STEP;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_DATA: begin
        if (bus_ack)         state_d = ST_STEP;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_STEP: begin
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus and step outputs depend only on the state register and core inputs.
  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_mask    = '0;
    core_clk_en = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = inst_addr;
        bus_mask = 4'b1111;
      end
      ST_DATA: begin
        bus_req   = 1'b1;
        bus_we    = data_we;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
        bus_mask  = data_mask;
      end
      ST_STEP: begin
        core_clk_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (state_d == ST_ERROR) err_q <= 1'b1;
      if ((state_q == ST_FETCH) && bus_ack) inst_q <= bus_rdata;
      if ((state_q == ST_DATA) && bus_ack && !data_we) rdata_q <= bus_rdata;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [29:0] inst_addr = '0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [29:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_mask = '0;
  logic        core_clk_en;
  logic [31:0] inst_q;
  logic [31:0] rdata_q;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .inst_addr   (inst_addr),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_mask   (data_mask),
    .core_clk_en (core_clk_en),
    .inst_q      (inst_q),
    .rdata_q     (rdata_q),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_mask    (bus_mask),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Memory model: ack after dly wait cycles; address 0x200 holds 0xDEADBEEF,
  // every other word reads as {2'b00, addr} ^ 0xC0DE0000.
  int   dly = 0;
  logic ack_en = 1'b1;
  logic force_ack = 1'b0;
  int   wcnt = 0;

  always @(posedge clk) begin
    if (bus_req && !bus_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  assign bus_ack   = force_ack | (ack_en & bus_req & (wcnt >= dly));
  assign bus_rdata = (bus_addr == 30'h200) ? 32'hDEADBEEF
                                           : ({2'b00, bus_addr} ^ 32'hC0DE0000);

  typedef struct {
    logic        dreq;
    logic        dwe;
    logic [29:0] iaddr;
    logic [29:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          dly;
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
    int          exp_req_cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = bus_req;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    logic in_data;
    logic done;
    cyc = 0; in_data = 1'b0; done = 1'b0;
    inst_addr = v.iaddr; data_req = v.dreq; data_we = v.dwe;
    data_addr = v.daddr; data_wdata = v.wdata; data_mask = v.mask;
    dly = v.dly; run = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (bus_req) begin
        cyc++;
        run = 1'b0;
        if (!in_data) begin
          chk($sformatf("v%0d_fetch_addr", idx), {2'b00, bus_addr}, {2'b00, v.iaddr});
          chk($sformatf("v%0d_fetch_we", idx), {31'd0, bus_we}, 32'd0);
          chk($sformatf("v%0d_fetch_mask", idx), {28'd0, bus_mask}, 32'hF);
          if (bus_ack && v.dreq) in_data = 1'b1;
        end else begin
          chk($sformatf("v%0d_data_addr", idx), {2'b00, bus_addr}, {2'b00, v.daddr});
          chk($sformatf("v%0d_data_we", idx), {31'd0, bus_we}, {31'd0, v.dwe});
          chk($sformatf("v%0d_data_mask", idx), {28'd0, bus_mask}, {28'd0, v.mask});
          chk($sformatf("v%0d_data_wdata", idx), bus_wdata, v.wdata);
        end
      end else if (core_clk_en) begin
        done = 1'b1;
        chk($sformatf("v%0d_req_cycles", idx), cyc, v.exp_req_cycles);
        chk($sformatf("v%0d_inst_q", idx), inst_q, v.exp_inst);
        chk($sformatf("v%0d_rdata_q", idx), rdata_q, v.exp_rdata);
      end
    end
    chk($sformatf("v%0d_step_seen", idx), {31'd0, done}, 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_after_clken", idx), {31'd0, core_clk_en}, 32'd0);
    chk($sformatf("v%0d_after_req", idx), {31'd0, bus_req}, 32'd0);
    chk($sformatf("v%0d_inst_hold", idx), inst_q, v.exp_inst);
  endtask

  initial begin
    int   cnt;
    int   pulses;
    logic seen_data;
    logic bad;

    //          dreq  dwe   iaddr        daddr        wdata          mask     dly inst           rdata          cyc
    vecs[0] = '{1'b0, 1'b0, 30'h10,       30'h0,       32'h0,         4'b0000, 0, 32'hC0DE0010, 32'h00000000, 1};
    vecs[1] = '{1'b1, 1'b0, 30'h14,       30'h200,     32'h0,         4'b1111, 2, 32'hC0DE0014, 32'hDEADBEEF, 6};
    vecs[2] = '{1'b1, 1'b1, 30'h18,       30'h300,     32'h00001234,  4'b0011, 1, 32'hC0DE0018, 32'hDEADBEEF, 4};
    vecs[3] = '{1'b1, 1'b0, 30'h3FFFFFFF, 30'h0AB,     32'h0,         4'b1111, 0, 32'hFF21FFFF, 32'hC0DE00AB, 2};
    vecs[4] = '{1'b1, 1'b1, 30'h0,        30'h3FFFFFFF, 32'hA5A5A5A5, 4'b1000, 3, 32'hC0DE0000, 32'hC0DE00AB, 8};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_clken", {31'd0, core_clk_en}, 32'd0);
    chk("rst_inst_q", inst_q, 32'd0);
    chk("rst_rdata_q", rdata_q, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Back-to-back steps with zero-wait acks: fetch/step alternate
    inst_addr = 30'h10; data_req = 1'b0; dly = 0; run = 1'b1;
    wait_req("steady_start");
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("steady_clken_%0d", i), {31'd0, core_clk_en}, (i % 2));
      chk($sformatf("steady_req_%0d", i), {31'd0, bus_req}, ((i + 1) % 2));
      if (bus_req) chk($sformatf("steady_addr_%0d", i), {2'b00, bus_addr}, 32'h10);
      if (i == 7) run = 1'b0;
    end
    @(negedge clk);
    chk("steady_idle_req", {31'd0, bus_req}, 32'd0);
    chk("steady_inst_q", inst_q, 32'hC0DE0010);

    // run dropped during DATA: access completes, one step, then idle
    inst_addr = 30'h20; data_req = 1'b1; data_we = 1'b0; data_addr = 30'h200;
    data_mask = 4'hF; dly = 2; run = 1'b1;
    wait_req("rundrop_start");
    pulses = 0; seen_data = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus_req && bus_addr == 30'h200) begin
        seen_data = 1'b1;
        run = 1'b0;
      end
      if (core_clk_en) pulses++;
    end
    chk("rundrop_seen_data", {31'd0, seen_data}, 32'd1);
    chk("rundrop_pulses", pulses, 32'd1);
    chk("rundrop_idle_req", {31'd0, bus_req}, 32'd0);
    chk("rundrop_rdata_q", rdata_q, 32'hDEADBEEF);
    chk("rundrop_inst_q", inst_q, 32'hC0DE0020);

    // Reset mid-FETCH, then a stray ack right after release
    inst_addr = 30'h40; data_req = 1'b0; dly = 5; run = 1'b1;
    wait_req("midrst_start");
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus_req}, 32'd0);
    chk("midrst_clken", {31'd0, core_clk_en}, 32'd0);
    chk("midrst_inst_q", inst_q, 32'd0);
    chk("midrst_rdata_q", rdata_q, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("lateack_inst_q", inst_q, 32'd0);
    chk("lateack_req", {31'd0, bus_req}, 32'd0);
    chk("lateack_clken", {31'd0, core_clk_en}, 32'd0);

    // No ack ever: 255 wait cycles, then sticky error
    ack_en = 1'b0; inst_addr = 30'h50; run = 1'b1;
    wait_req("timeout_start");
    cnt = 1;
    for (int k = 0; k < 400 && bus_req; k++) begin
      @(negedge clk);
      if (bus_req) cnt++;
    end
    chk("timeout_req_cycles", cnt, 32'd255);
    chk("timeout_err", {31'd0, err}, 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_clk_en || bus_req || !err) bad = 1'b1;
    end
    chk("timeout_stuck", {31'd0, bad}, 32'd0);

    // Reset clears error; first fetch on the second edge after release
    rst = 1'b0; ack_en = 1'b1; dly = 0;
    @(negedge clk);
    chk("err_cleared", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_edge_idle", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("second_edge_fetch", {31'd0, bus_req}, 32'd1);
    run = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
